// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RISC datapath controller.
// Moore FSM with memory-handshake stalls and a sticky illegal flag.
module mc_ctrl_fsm #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2,
  parameter int EN_ADDI = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pc_wr,
  output logic               pc_wr_cond,
  output logic               iord,
  output logic               ir_wr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               reg_wr,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state,
  output logic               retire,
  output logic               illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMMS = 2'b11;

  localparam logic [1:0] PCS_ALU   = 2'b00;
  localparam logic [1:0] PCS_OUT   = 2'b01;
  localparam logic [1:0] PCS_JMP   = 2'b10;

  localparam logic [1:0] AOP_FUNCT = 2'b00;
  localparam logic [1:0] AOP_ADD   = 2'b01;
  localparam logic [1:0] AOP_SUB   = 2'b10;

  state_e state_q;
  state_e state_d;
  logic   illegal_q;
  logic   illegal_d;

  logic       is_rtype;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_j;
  logic       is_addi;
  logic [1:0] aop;

  assign is_rtype = (opcode == OP_W'(OPC_RTYPE));
  assign is_lw    = (opcode == OP_W'(OPC_LW));
  assign is_sw    = (opcode == OP_W'(OPC_SW));
  assign is_beq   = (opcode == OP_W'(OPC_BEQ));
  assign is_j     = (opcode == OP_W'(OPC_J));
  assign is_addi  = (EN_ADDI != 0)
                 && (opcode == OP_W'(OPC_ADDI));

  // State and sticky illegal flag; reset aborts any instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: memory states wait on mem_ready, DECODE dispatches
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_rtype:       state_d = S_EXEC;
          is_lw || is_sw: state_d = S_MEMADR;
          is_beq:         state_d = S_BRANCH;
          is_j:           state_d = S_JUMP;
          is_addi:        state_d = S_IEXEC;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        state_d = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
    if (state_d == S_TRAP) illegal_d = 1'b1;
  end

  // Moore decode; FETCH write strobes wait for the memory and reset
  always_comb begin
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    iord       = 1'b0;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCS_ALU;
    aop        = AOP_FUNCT;
    retire     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        aop       = AOP_ADD;
        pc_src    = PCS_ALU;
        ir_wr     = mem_ready & rst_n;
        pc_wr     = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMS;
        aop       = AOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aop       = AOP_ADD;
      end
      S_MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        retire = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        aop       = AOP_FUNCT;
      end
      S_RWB: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        aop        = AOP_SUB;
        pc_wr_cond = 1'b1;
        pc_src     = PCS_OUT;
        retire     = 1'b1;
      end
      S_JUMP: begin
        pc_wr  = 1'b1;
        pc_src = PCS_JMP;
        retire = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aop       = AOP_ADD;
      end
      S_IWB: begin
        reg_wr = 1'b1;
        retire = 1'b1;
      end
      S_TRAP: begin
        retire = 1'b0;
      end
      default: begin
        retire = 1'b0;
      end
    endcase
  end

  assign alu_op  = ALUOP_W'(aop);
  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm.
// Two builds: default, and one with addi disabled.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b0, mr0 = 1'b1;
  logic [5:0] op0 = '0;
  logic       rst1 = 1'b0, mr1 = 1'b1;
  logic [5:0] op1 = '0;

  logic       pcw0, pcwc0, iord0, irw0, mrd0, mwr0;
  logic       rw0, rd0, m2r0, sa0, ret0, ill0;
  logic [1:0] sb0, ps0, ao0;
  logic [3:0] st0;
  logic       pcw1, pcwc1, iord1, irw1, mrd1, mwr1;
  logic       rw1, rd1, m2r1, sa1, ret1, ill1;
  logic [1:0] sb1, ps1, ao1;
  logic [3:0] st1;

  mc_ctrl_fsm u0 (
    .clk(clk), .rst_n(rst0), .opcode(op0), .mem_ready(mr0),
    .pc_wr(pcw0), .pc_wr_cond(pcwc0), .iord(iord0),
    .ir_wr(irw0), .mem_rd(mrd0), .mem_wr(mwr0),
    .reg_wr(rw0), .reg_dst(rd0), .mem_to_reg(m2r0),
    .alu_src_a(sa0), .alu_src_b(sb0), .pc_src(ps0),
    .alu_op(ao0), .state(st0), .retire(ret0),
    .illegal(ill0)
  );

  mc_ctrl_fsm #(.EN_ADDI(0)) u1 (
    .clk(clk), .rst_n(rst1), .opcode(op1), .mem_ready(mr1),
    .pc_wr(pcw1), .pc_wr_cond(pcwc1), .iord(iord1),
    .ir_wr(irw1), .mem_rd(mrd1), .mem_wr(mwr1),
    .reg_wr(rw1), .reg_dst(rd1), .mem_to_reg(m2r1),
    .alu_src_a(sa1), .alu_src_b(sb1), .pc_src(ps1),
    .alu_op(ao1), .state(st1), .retire(ret1),
    .illegal(ill1)
  );

  logic [21:0] obs0, obs1;
  assign obs0 = {st0, pcw0, pcwc0, iord0, irw0, mrd0, mwr0,
                 rw0, rd0, m2r0, sa0, sb0, ps0, ao0, ret0, ill0};
  assign obs1 = {st1, pcw1, pcwc1, iord1, irw1, mrd1, mwr1,
                 rw1, rd1, m2r1, sa1, sb1, ps1, ao1, ret1, ill1};

  typedef struct packed {
    logic [21:0] v;
    int          tag;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tag = 0;
  int   exp_ret = 0;
  int   obs_ret = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BQ = 6'b000100;
  localparam logic [5:0] JP = 6'b000010, AD = 6'b001000;

  localparam int NV = 9;
  localparam logic [5:0] V_OP [NV] =
    '{LW, SW, RT, BQ, JP, AD, SW, LW, RT};
  localparam int V_N [NV] = '{5, 4, 4, 3, 3, 4, 7, 8, 4};
  localparam logic [31:0] V_ST [NV] = '{
    32'h00043210, 32'h00005210, 32'h00007610,
    32'h00000810, 32'h00000910, 32'h0000BA10,
    32'h05555210, 32'h43321000, 32'h00007610};
  localparam logic [7:0] V_MR [NV] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'hC7, 8'hDC, 8'h01};

  // Expected output bundle per state, from the state table
  function automatic logic [21:0] expv(
    input logic [3:0] s, input logic mr, input logic rv);
    logic pcw, pcwc, io, irw, mrd, mwr;
    logic rw, rd, m2r, sa, ret, ill;
    logic [1:0] sb, ps, ao;
    {pcw, pcwc, io, irw, mrd, mwr} = '0;
    {rw, rd, m2r, sa, ret, ill} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      4'd0: begin
        mrd = 1; sb = 2'b01; ao = 2'b01;
        irw = mr & rv; pcw = mr & rv;
      end
      4'd1: begin sb = 2'b11; ao = 2'b01; end
      4'd2: begin sa = 1; sb = 2'b10; ao = 2'b01; end
      4'd3: begin mrd = 1; io = 1; end
      4'd4: begin rw = 1; m2r = 1; ret = 1; end
      4'd5: begin mwr = 1; io = 1; ret = mr; end
      4'd6: begin sa = 1; end
      4'd7: begin rw = 1; rd = 1; ret = 1; end
      4'd8: begin
        sa = 1; ao = 2'b10; pcwc = 1; ps = 2'b01; ret = 1;
      end
      4'd9: begin pcw = 1; ps = 2'b10; ret = 1; end
      4'd10: begin sa = 1; sb = 2'b10; ao = 2'b01; end
      4'd11: begin rw = 1; ret = 1; end
      4'd12: begin ill = 1; end
      default: begin end
    endcase
    return {s, pcw, pcwc, io, irw, mrd, mwr,
            rw, rd, m2r, sa, sb, ps, ao, ret, ill};
  endfunction

  // Monitor: compare each presented cycle against the scoreboard
  always @(negedge clk) begin
    rec_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n_vec++;
      if (obs0 !== e.v) begin
        n_bad++;
        $display("FAIL trace0 tag=%0d got=%h exp=%h",
                 e.tag, obs0, e.v);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      n_vec++;
      if (obs1 !== e.v) begin
        n_bad++;
        $display("FAIL trace1 tag=%0d got=%h exp=%h",
                 e.tag, obs1, e.v);
      end
    end
    if (ret0 === 1'b1) obs_ret++;
  end

  task automatic cyc(input bit w, input logic [3:0] s,
                     input logic mr, input logic rv);
    rec_t r;
    r.v = expv(s, mr, rv);
    r.tag = tag;
    tag++;
    if (!w) begin
      mr0 = mr; rst0 = rv; q0.push_back(r);
    end else begin
      mr1 = mr; rst1 = rv; q1.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_instr();
    logic [3:0] path[$];
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0: begin op0 = LW; path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}; end
      1: begin op0 = SW; path = '{4'd0, 4'd1, 4'd2, 4'd5}; end
      2: begin op0 = RT; path = '{4'd0, 4'd1, 4'd6, 4'd7}; end
      3: begin op0 = BQ; path = '{4'd0, 4'd1, 4'd8}; end
      4: begin op0 = JP; path = '{4'd0, 4'd1, 4'd9}; end
      default: begin op0 = AD; path = '{4'd0, 4'd1, 4'd10, 4'd11}; end
    endcase
    foreach (path[i]) begin
      if (path[i] inside {4'd0, 4'd3, 4'd5}) begin
        repeat ($urandom_range(0, 2)) cyc(0, path[i], 1'b0, 1'b1);
        cyc(0, path[i], 1'b1, 1'b1);
      end else begin
        cyc(0, path[i], 1'($urandom_range(0, 1)), 1'b1);
      end
    end
    exp_ret++;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 4'd0, 1'b1, 1'b0);
    cyc(0, 4'd0, 1'b1, 1'b0);

    for (int i = 0; i < NV; i++) begin
      op0 = V_OP[i];
      for (int c = 0; c < V_N[i]; c++)
        cyc(0, V_ST[i][4*c +: 4], V_MR[i][c], 1'b1);
      exp_ret++;
    end

    for (int i = 0; i < 16; i++) rand_instr();

    op0 = SW;
    cyc(0, 4'd0, 1'b1, 1'b1);
    cyc(0, 4'd1, 1'b1, 1'b1);
    cyc(0, 4'd2, 1'b1, 1'b1);
    cyc(0, 4'd5, 1'b0, 1'b1);
    cyc(0, 4'd5, 1'b0, 1'b1);
    cyc(0, 4'd0, 1'b1, 1'b0);
    cyc(0, 4'd0, 1'b1, 1'b1);
    cyc(0, 4'd1, 1'b1, 1'b1);
    cyc(0, 4'd2, 1'b1, 1'b1);
    cyc(0, 4'd5, 1'b1, 1'b1);
    exp_ret++;

    op0 = 6'b111111;
    cyc(0, 4'd0, 1'b1, 1'b1);
    cyc(0, 4'd1, 1'b1, 1'b1);
    cyc(0, 4'd12, 1'b1, 1'b1);
    cyc(0, 4'd12, 1'b0, 1'b1);
    cyc(0, 4'd12, 1'b1, 1'b1);
    cyc(0, 4'd0, 1'b1, 1'b0);
    op0 = JP;
    cyc(0, 4'd0, 1'b1, 1'b1);
    cyc(0, 4'd1, 1'b1, 1'b1);
    cyc(0, 4'd9, 1'b1, 1'b1);
    exp_ret++;

    mr0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs_ret != exp_ret) begin
      n_bad++;
      $display("FAIL retire_count got=%0d exp=%0d",
               obs_ret, exp_ret);
    end
    rst0 = 1'b0;

    op1 = AD;
    cyc(1, 4'd0, 1'b1, 1'b0);
    cyc(1, 4'd0, 1'b1, 1'b1);
    cyc(1, 4'd1, 1'b1, 1'b1);
    cyc(1, 4'd12, 1'b1, 1'b1);
    cyc(1, 4'd12, 1'b1, 1'b1);
    cyc(1, 4'd12, 1'b1, 1'b1);
    cyc(1, 4'd0, 1'b1, 1'b0);
    op1 = LW;
    cyc(1, 4'd0, 1'b1, 1'b1);
    cyc(1, 4'd1, 1'b1, 1'b1);
    cyc(1, 4'd2, 1'b1, 1'b1);
    cyc(1, 4'd3, 1'b1, 1'b1);
    cyc(1, 4'd4, 1'b1, 1'b1);
    cyc(1, 4'd0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
